mc_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the RV32I core. It replaces the ad-hoc stage control with an explicit FSM that issues PC, instruction-register, register-file and memory strobes. The memory port uses a ready/request handshake with variable latency, and the block adds a stall input, a bus-timeout watchdog, halting on SYSTEM or illegal opcodes, and cycle/retired-instruction counters. It sits between the instruction decoder and the datapath enables in `top`.

---
 rtl/mc_pkg.sv | 47 ++++
 rtl/mc_wait_timer.sv | 34 +++
 rtl/mc_sequencer.sv | 179 +++++++++++++++++
 tb/tb_mc_sequencer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle control sequencer.
// Contents: FSM state encoding, RV32I major opcodes, next-PC and write-back
// source selects, and a helper that recognises the supported opcodes.
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5
    } state_e;

    typedef enum logic [1:0] {
        PC_PLUS4   = 2'd0,
        PC_IMM     = 2'd1,
        PC_RS1_IMM = 2'd2
    } pc_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2,
        WB_IMM = 2'd3
    } wb_sel_e;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    function automatic logic is_known_opcode(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
            OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory-handshake watchdog.
// Counts cycles with an outstanding request (busy) that is not acknowledged
// (ready). expired pulses in the cycle whose un-acknowledged wait is the
// TIMEOUT_CYCLES-th one; an acknowledge in that same cycle suppresses it.
// Ports: clk, reset (sync, active-high), busy, ready, clear (state change),
//        expired (1-cycle pulse).
module mc_wait_timer #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic busy,
    input  logic ready,
    input  logic clear,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LIMIT    = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT_M1 = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count;

    // Saturate at the limit so the pulse cannot fire a second time.
    always_ff @(posedge clk) begin
        if (reset || clear || ready)
            count <= '0;
        else if (busy && count != LIMIT)
            count <= count + CW'(1);
    end

    assign expired = busy && !ready && !clear && (count == LIMIT_M1);

endmodule

// File: rtl/mc_sequencer.sv
// Multicycle control sequencer for the RV32I core.
// Drives PC / IR / register-file / memory strobes from an explicit FSM,
// with a variable-latency ready/request memory handshake, a fetch stall,
// a bus watchdog, halting on SYSTEM or unknown opcodes, and cycle/instret
// counters.
// Ports: clk, reset (sync, active-high); opcode, branch_taken, mem_ready,
//        stall_req in; ir_en, pc_en, pc_sel, mem_req, mem_we, mem_addr_sel,
//        reg_we, wb_sel strobes out; state, halted, illegal_err,
//        timeout_err, cycle_count, instret status out.
module mc_sequencer #(
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter bit HALT_ON_SYSTEM = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic             branch_taken,
    input  logic             mem_ready,
    input  logic             stall_req,
    output logic             ir_en,
    output logic             pc_en,
    output logic [1:0]       pc_sel,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_addr_sel,
    output logic             reg_we,
    output logic [1:0]       wb_sel,
    output logic [2:0]       state,
    output logic             halted,
    output logic             illegal_err,
    output logic             timeout_err,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instret
);
    import mc_pkg::*;

    state_e  state_q, state_d;
    pc_sel_e pc_sel_w;
    wb_sel_e wb_sel_w;
    logic    retire;
    logic    set_illegal;
    logic    fetch_pend;   // fetch request already raised and not yet acked
    logic    wd_expired;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_FETCH;
            cycle_count <= '0;
            instret     <= '0;
            illegal_err <= 1'b0;
            timeout_err <= 1'b0;
            fetch_pend  <= 1'b0;
        end else begin
            state_q    <= state_d;
            fetch_pend <= (state_q == S_FETCH) && mem_req && !mem_ready;
            if (state_q != S_HALT)
                cycle_count <= cycle_count + CNT_W'(1);
            if (retire)
                instret <= instret + CNT_W'(1);
            if (set_illegal)
                illegal_err <= 1'b1;
            if (wd_expired)
                timeout_err <= 1'b1;
        end
    end

    always_comb begin
        state_d      = state_q;
        ir_en        = 1'b0;
        pc_en        = 1'b0;
        pc_sel_w     = PC_PLUS4;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        reg_we       = 1'b0;
        wb_sel_w     = WB_ALU;
        retire       = 1'b0;
        set_illegal  = 1'b0;

        // A fired watchdog abandons whatever was in flight: no strobes,
        // straight to HALT on this edge.
        if (timeout_err && state_q != S_HALT) begin
            state_d = S_HALT;
        end else begin
            case (state_q)
                S_FETCH: begin
                    // Stall only before the request goes out; once raised,
                    // the request is held until acknowledged.
                    if (!stall_req || fetch_pend) begin
                        mem_req = 1'b1;
                        if (mem_ready) begin
                            ir_en   = 1'b1;
                            state_d = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    if (HALT_ON_SYSTEM && opcode == OPC_SYSTEM) begin
                        state_d = S_HALT;
                    end else if (!is_known_opcode(opcode)) begin
                        set_illegal = 1'b1;
                        state_d     = S_HALT;
                    end else begin
                        state_d = S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (opcode)
                        OPC_LOAD, OPC_STORE: state_d = S_MEM;
                        OPC_BRANCH: begin
                            pc_en    = 1'b1;
                            pc_sel_w = branch_taken ? PC_IMM : PC_PLUS4;
                            retire   = 1'b1;
                            state_d  = S_FETCH;
                        end
                        // Only reachable when SYSTEM retires as a no-op.
                        OPC_SYSTEM: begin
                            pc_en   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end
                        default: state_d = S_WB;
                    endcase
                end
                S_MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = 1'b1;
                    mem_we       = (opcode == OPC_STORE);
                    if (mem_ready) begin
                        if (opcode == OPC_STORE) begin
                            pc_en   = 1'b1;
                            retire  = 1'b1;
                            state_d = S_FETCH;
                        end else begin
                            state_d = S_WB;
                        end
                    end
                end
                S_WB: begin
                    reg_we  = 1'b1;
                    pc_en   = 1'b1;
                    retire  = 1'b1;
                    state_d = S_FETCH;
                    case (opcode)
                        OPC_LOAD:          wb_sel_w = WB_MEM;
                        OPC_JAL, OPC_JALR: wb_sel_w = WB_PC4;
                        OPC_LUI:           wb_sel_w = WB_IMM;
                        default:           wb_sel_w = WB_ALU;
                    endcase
                    case (opcode)
                        OPC_JAL:  pc_sel_w = PC_IMM;
                        OPC_JALR: pc_sel_w = PC_RS1_IMM;
                        default:  pc_sel_w = PC_PLUS4;
                    endcase
                end
                S_HALT:  state_d = S_HALT;
                default: state_d = S_FETCH;
            endcase
        end
    end

    mc_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .busy    (mem_req),
        .ready   (mem_ready),
        .clear   (state_d != state_q),
        .expired (wd_expired)
    );

    assign pc_sel = pc_sel_w;
    assign wb_sel = wb_sel_w;
    assign state  = state_q;
    assign halted = (state_q == S_HALT);

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed bench for mc_sequencer (TIMEOUT_CYCLES = 4).
module tb_mc_sequencer;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] SYSTEM = 7'b1110011;

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  opcode;
    logic        branch_taken;
    logic        mem_ready;
    logic        stall_req;
    logic        ir_en, pc_en, mem_req, mem_we, mem_addr_sel, reg_we;
    logic [1:0]  pc_sel, wb_sel;
    logic [2:0]  state;
    logic        halted, illegal_err, timeout_err;
    logic [31:0] cycle_count, instret;

    int n_chk  = 0;
    int n_fail = 0;

    mc_sequencer #(
        .CNT_W          (32),
        .TIMEOUT_CYCLES (4),
        .HALT_ON_SYSTEM (1'b1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .branch_taken (branch_taken),
        .mem_ready    (mem_ready),
        .stall_req    (stall_req),
        .ir_en        (ir_en),
        .pc_en        (pc_en),
        .pc_sel       (pc_sel),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr_sel (mem_addr_sel),
        .reg_we       (reg_we),
        .wb_sel       (wb_sel),
        .state        (state),
        .halted       (halted),
        .illegal_err  (illegal_err),
        .timeout_err  (timeout_err),
        .cycle_count  (cycle_count),
        .instret      (instret)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        reset = 1'b0; opcode = OP_IMM; branch_taken = 1'b0;
        mem_ready = 1'b0; stall_req = 1'b0;
        #2;
        do_reset();

        // reset state
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cycle", cycle_count, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_ill", 32'(illegal_err), 32'd0);
        chk("rst_to", 32'(timeout_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd1);
        chk("rst_strobes", {26'd0, ir_en, pc_en, reg_we, mem_we, mem_addr_sel, halted}, 32'd0);

        // ADDI, mem_ready tied high: 0,1,2,4,0
        mem_ready = 1'b1; opcode = OP_IMM; #1;
        chk("addi_ir_en", 32'(ir_en), 32'd1);
        tick(); chk("addi_s1", 32'(state), 32'd1);
        tick(); chk("addi_s2", 32'(state), 32'd2);
        chk("addi_exec_pc_en", 32'(pc_en), 32'd0);
        tick(); chk("addi_s4", 32'(state), 32'd4);
        chk("addi_wb_strobes", {30'd0, reg_we, pc_en}, 32'd3);
        chk("addi_wb_sel", 32'(wb_sel), 32'd0);
        chk("addi_instret_pre", instret, 32'd0);
        tick(); chk("addi_s0", 32'(state), 32'd0);
        chk("addi_instret", instret, 32'd1);
        chk("addi_cycles", cycle_count, 32'd4);

        // LW with 3 wait cycles in MEM; ack on the 4th cycle (watchdog boundary)
        opcode = LOAD; mem_ready = 1'b1; #1;
        tick(); mem_ready = 1'b0; #1;
        tick(); chk("lw_exec", 32'(state), 32'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("lw_mem_wait", {29'd0, mem_req, mem_we, mem_addr_sel}, 32'b101);
            chk("lw_mem_state", 32'(state), 32'd3);
        end
        tick(); mem_ready = 1'b1; #1;
        chk("lw_mem_ack_state", 32'(state), 32'd3);
        tick(); chk("lw_wb_state", 32'(state), 32'd4);
        chk("lw_wb_sel", 32'(wb_sel), 32'd1);
        chk("lw_reg_we", 32'(reg_we), 32'd1);
        chk("lw_no_timeout", 32'(timeout_err), 32'd0);
        tick(); chk("lw_fetch", 32'(state), 32'd0);
        chk("lw_instret", instret, 32'd2);
        chk("lw_cycles", cycle_count, 32'd12);

        // BEQ taken
        opcode = BRANCH; branch_taken = 1'b1;
        tick(); tick();
        chk("beq_exec", 32'(state), 32'd2);
        chk("beq_pc_en", 32'(pc_en), 32'd1);
        chk("beq_pc_sel", 32'(pc_sel), 32'd1);
        tick(); chk("beq_fetch", 32'(state), 32'd0);
        chk("beq_instret", instret, 32'd3);
        chk("beq_cycles", cycle_count, 32'd15);
        branch_taken = 1'b0;

        // JALR
        opcode = JALR;
        tick(); tick(); tick();
        chk("jalr_wb", 32'(state), 32'd4);
        chk("jalr_pc_sel", 32'(pc_sel), 32'd2);
        chk("jalr_wb_sel", 32'(wb_sel), 32'd2);
        tick();

        // STORE: retires from MEM, 4 cycles
        opcode = STORE;
        tick(); tick(); tick();
        chk("sw_mem", {28'd0, state == 3'd3, mem_we, pc_en, reg_we}, 32'b1110);
        tick(); chk("sw_fetch", 32'(state), 32'd0);
        chk("sw_instret", instret, 32'd5);
        chk("sw_cycles", cycle_count, 32'd23);

        // stall for 5 cycles in FETCH
        stall_req = 1'b1; mem_ready = 1'b0; #1;
        chk("stall_req0", 32'(mem_req), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_mem_req", 32'(mem_req), 32'd0);
        end
        chk("stall_cycles", cycle_count, 32'd28);
        chk("stall_instret", instret, 32'd5);
        chk("stall_state", 32'(state), 32'd0);

        // stall ignored once the request is out
        stall_req = 1'b0; #1;
        chk("fetch_req", 32'(mem_req), 32'd1);
        tick(); stall_req = 1'b1; #1;
        chk("stall_ignored", 32'(mem_req), 32'd1);

        // SYSTEM halts
        opcode = SYSTEM; mem_ready = 1'b1;
        tick(); tick();
        chk("sys_halt", 32'(halted), 32'd1);
        chk("sys_no_ill", 32'(illegal_err), 32'd0);
        chk("sys_instret", instret, 32'd5);
        stall_req = 1'b0;

        // watchdog: mem_ready stuck low in FETCH
        mem_ready = 1'b0; opcode = OP_IMM;
        do_reset();
        repeat (4) tick();
        chk("wd_err", 32'(timeout_err), 32'd1);
        chk("wd_not_yet_halted", 32'(halted), 32'd0);
        tick();
        chk("wd_halted", 32'(halted), 32'd1);
        chk("wd_cycles", cycle_count, 32'd5);
        repeat (3) tick();
        chk("wd_cycles_frozen", cycle_count, 32'd5);

        // illegal opcode, then reset recovers
        do_reset();
        chk("wd_reset_err", 32'(timeout_err), 32'd0);
        mem_ready = 1'b1; opcode = 7'h7F;
        tick(); chk("ill_decode", 32'(state), 32'd1);
        tick();
        chk("ill_err", 32'(illegal_err), 32'd1);
        chk("ill_halt", 32'(state), 32'd5);
        tick(); tick();
        chk("ill_absorb", 32'(state), 32'd5);
        do_reset();
        chk("ill_rst_state", 32'(state), 32'd0);
        chk("ill_rst_err", 32'(illegal_err), 32'd0);
        chk("ill_rst_cycles", cycle_count, 32'd0);
        chk("ill_rst_instret", instret, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
